// File: rtl/hazard_scroller.sv
// hazard_scroller: scrolls obstacle/enemy hazards once per frame tick, tracks score and speed,
// and freezes the playfield on death. Rev 1.0
`default_nettype none

module hazard_scroller #(
  parameter int         SCREEN_W     = 640,
  parameter int         ENEMY_GAP    = 320,
  parameter int         OBST_V       = 330,
  parameter int         ENEMY_V_LOW  = 330,
  parameter int         ENEMY_V_HIGH = 290,
  parameter int         SPEED_INIT   = 2,
  parameter int         SPEED_MAX    = 8,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        tick,
  input  logic        start,
  input  logic        is_alive,
  output logic [9:0]  obstacle_h,
  output logic [9:0]  obstacle_v,
  output logic [9:0]  enemy_h,
  output logic [9:0]  enemy_v,
  output logic [15:0] score,
  output logic        running,
  output logic        game_over
);

  localparam logic [9:0] SPAWN_H    = 10'(SCREEN_W);
  localparam logic [9:0] ENEMY_H0   = 10'(SCREEN_W + ENEMY_GAP);
  localparam logic [9:0] OBST_V_C   = 10'(OBST_V);
  localparam logic [9:0] EV_LOW     = 10'(ENEMY_V_LOW);
  localparam logic [9:0] EV_HIGH    = 10'(ENEMY_V_HIGH);
  localparam logic [9:0] SPD_INIT   = 10'(SPEED_INIT);
  localparam logic [9:0] SPD_MAX    = 10'(SPEED_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t      state;
  logic [9:0]  speed;
  logic [7:0]  lfsr;

  logic        lfsr_fb;
  logic [15:0] score_inc;
  logic        score_sat;
  logic        speed_bump;

  assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign score_inc  = score + 16'd1;
  assign score_sat  = (score == 16'hFFFF);
  // Speed steps every 256 ticks survived; the bump takes effect on the following tick.
  assign speed_bump = !score_sat && (score_inc[7:0] == 8'h00) && (speed < SPD_MAX);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      obstacle_h <= SPAWN_H;
      obstacle_v <= OBST_V_C;
      enemy_h    <= ENEMY_H0;
      enemy_v    <= EV_LOW;
      score      <= 16'd0;
      speed      <= SPD_INIT;
      lfsr       <= LFSR_SEED;
      running    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      // Free-running so respawn height depends on when the player starts and survives.
      lfsr <= {lfsr[6:0], lfsr_fb};

      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end

        RUN: begin
          if (!is_alive) begin
            state     <= DEAD;
            running   <= 1'b0;
            game_over <= 1'b1;
          end else if (tick) begin
            if (obstacle_h <= speed) obstacle_h <= SPAWN_H;
            else                     obstacle_h <= obstacle_h - speed;

            if (enemy_h <= speed) begin
              enemy_h <= SPAWN_H;
              enemy_v <= lfsr[0] ? EV_HIGH : EV_LOW;
            end else begin
              enemy_h <= enemy_h - speed;
            end

            if (!score_sat) score <= score_inc;
            if (speed_bump) speed <= speed + 10'd1;
          end
        end

        DEAD: begin
          if (start) begin
            state      <= RUN;
            running    <= 1'b1;
            game_over  <= 1'b0;
            obstacle_h <= SPAWN_H;
            obstacle_v <= OBST_V_C;
            enemy_h    <= ENEMY_H0;
            enemy_v    <= EV_LOW;
            score      <= 16'd0;
            speed      <= SPD_INIT;
          end
        end

        default: begin
          state     <= IDLE;
          running   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scroller.sv
// tb_hazard_scroller: scoreboard bench for hazard_scroller, default and narrow-screen instances.
`default_nettype none

module tb_hazard_scroller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr, tick, start, is_alive;
  logic [9:0]  oh0, ov0, eh0, ev0, oh1, ov1, eh1, ev1;
  logic [15:0] sc0, sc1;
  logic        run0, run1, go0, go1;

  hazard_scroller dut0 (
    .clk(clk), .clr(clr), .tick(tick), .start(start), .is_alive(is_alive),
    .obstacle_h(oh0), .obstacle_v(ov0), .enemy_h(eh0), .enemy_v(ev0),
    .score(sc0), .running(run0), .game_over(go0)
  );

  hazard_scroller #(.SCREEN_W(100), .ENEMY_GAP(300)) dut1 (
    .clk(clk), .clr(clr), .tick(tick), .start(start), .is_alive(is_alive),
    .obstacle_h(oh1), .obstacle_v(ov1), .enemy_h(eh1), .enemy_v(ev1),
    .score(sc1), .running(run1), .game_over(go1)
  );

  typedef struct {
    int oh, ov, eh, ev, score, running, game_over;
  } exp_t;

  exp_t sb[$];

  int         m_state [2];
  int         m_oh    [2];
  int         m_eh    [2];
  int         m_ev    [2];
  int         m_score [2];
  int         m_speed [2];
  logic [7:0] m_lfsr  [2];
  int         m_sw    [2] = '{640, 100};
  int         m_gap   [2] = '{320, 300};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0;
      m_oh[d]    = m_sw[d];
      m_eh[d]    = m_sw[d] + m_gap[d];
      m_ev[d]    = 330;
      m_score[d] = 0;
      m_speed[d] = 2;
      m_lfsr[d]  = 8'hA5;
    end
    sb.delete();
  endfunction

  function automatic void model_clock(input bit tk, input bit st, input bit al);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      bit lsb;
      lsb = m_lfsr[d][0];
      if (m_state[d] == 0) begin
        if (st) m_state[d] = 1;
      end else if (m_state[d] == 1) begin
        if (!al) m_state[d] = 2;
        else if (tk) begin
          if (m_oh[d] <= m_speed[d]) m_oh[d] = m_sw[d];
          else m_oh[d] = m_oh[d] - m_speed[d];
          if (m_eh[d] <= m_speed[d]) begin
            m_eh[d] = m_sw[d];
            m_ev[d] = lsb ? 290 : 330;
          end else m_eh[d] = m_eh[d] - m_speed[d];
          if (m_score[d] < 65535) begin
            m_score[d]++;
            if ((m_score[d] % 256) == 0 && m_speed[d] < 8) m_speed[d]++;
          end
        end
      end else begin
        if (st) begin
          m_state[d] = 1;
          m_oh[d]    = m_sw[d];
          m_eh[d]    = m_sw[d] + m_gap[d];
          m_ev[d]    = 330;
          m_score[d] = 0;
          m_speed[d] = 2;
        end
      end
      m_lfsr[d] = {m_lfsr[d][6:0], ^(m_lfsr[d] & 8'b1011_1000)};
      e.oh = m_oh[d]; e.ov = 330; e.eh = m_eh[d]; e.ev = m_ev[d];
      e.score = m_score[d];
      e.running = (m_state[d] == 1) ? 1 : 0;
      e.game_over = (m_state[d] == 2) ? 1 : 0;
      sb.push_back(e);
    end
  endfunction

  // Called just after a rising edge; drives inputs, predicts, then compares after the next edge.
  task automatic step(input bit tk, input bit st, input bit al);
    exp_t e;
    tick = tk; start = st; is_alive = al;
    model_clock(tk, st, al);
    @(posedge clk);
    #1;
    check("sb_depth", (sb.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      check("obstacle_h0", oh0, e.oh);   check("obstacle_v0", ov0, e.ov);
      check("enemy_h0", eh0, e.eh);      check("enemy_v0", ev0, e.ev);
      check("score0", sc0, e.score);     check("running0", run0, e.running);
      check("game_over0", go0, e.game_over);
      e = sb.pop_front();
      check("obstacle_h1", oh1, e.oh);   check("obstacle_v1", ov1, e.ov);
      check("enemy_h1", eh1, e.eh);      check("enemy_v1", ev1, e.ev);
      check("score1", sc1, e.score);     check("running1", run1, e.running);
      check("game_over1", go1, e.game_over);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_oh0"}, oh0, 640);  check({tag, "_eh0"}, eh0, 960);
    check({tag, "_ev0"}, ev0, 330);  check({tag, "_ov0"}, ov0, 330);
    check({tag, "_sc0"}, sc0, 0);    check({tag, "_run0"}, run0, 0);
    check({tag, "_go0"}, go0, 0);    check({tag, "_oh1"}, oh1, 100);
    check({tag, "_eh1"}, eh1, 400);
  endtask

  initial begin
    clr = 1'b0; tick = 1'b0; start = 1'b0; is_alive = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    clr = 1'b1;

    repeat (10) step(1, 0, 1);
    check_reset_values("idle_ticks");

    step(0, 1, 1);
    check("start_running", run0, 1);
    for (int k = 1; k <= 257; k++) begin
      step(1, 0, 1);
      if (k == 1) begin
        check("tick1_oh0", oh0, 638); check("tick1_eh0", eh0, 958); check("tick1_sc0", sc0, 1);
      end
      if (k == 49)  check("wrap_pre_oh1", oh1, 2);
      if (k == 50)  check("wrap_oh1", oh1, 100);
      if (k == 199) check("wrap_pre_eh1", eh1, 2);
      if (k == 200) begin
        check("wrap_eh1", eh1, 100);
        check("wrap_ev1_set", (ev1 == 10'd290 || ev1 == 10'd330) ? 32'd1 : 32'd0, 32'd1);
      end
      if (k == 255) begin check("t255_oh0", oh0, 130); check("t255_sc0", sc0, 255); end
      if (k == 256) begin
        check("t256_oh0", oh0, 128); check("t256_sc0", sc0, 256); check("t256_speed0", dut0.speed, 3);
      end
      if (k == 257) check("t257_oh0", oh0, 125);
    end

    step(1, 0, 0);
    check("die_go0", go0, 1); check("die_run0", run0, 0);
    check("die_oh0", oh0, 125); check("die_sc0", sc0, 257);

    step(0, 1, 1);
    check("restart_oh0", oh0, 640); check("restart_eh0", eh0, 960);
    check("restart_sc0", sc0, 0);   check("restart_run0", run0, 1);
    check("restart_go0", go0, 0);   check("restart_speed0", dut0.speed, 2);

    step(1, 1, 1);
    repeat (19) step(1, 0, 1);
    check("pre_death_oh0", oh0, 600); check("pre_death_sc0", sc0, 20);
    step(1, 0, 0);
    check("death_go0", go0, 1); check("death_run0", run0, 0);
    check("death_oh0", oh0, 600); check("death_sc0", sc0, 20);
    repeat (5) step(1, 0, 1);
    check("dead_frozen_oh0", oh0, 600); check("dead_frozen_sc0", sc0, 20);
    check("dead_frozen_go0", go0, 1);

    step(0, 1, 1);
    for (int k = 1; k <= 70000; k++) begin
      step(1, 0, 1);
      check("range_oh0", (oh0 >= 10'd1 && oh0 <= 10'd640) ? 32'd1 : 32'd0, 32'd1);
      check("range_oh1", (oh1 >= 10'd1 && oh1 <= 10'd100) ? 32'd1 : 32'd0, 32'd1);
      if (k == 1535) check("speed_at_1535", dut0.speed, 7);
      if (k == 1536) check("speed_at_1536", dut0.speed, 8);
    end
    check("sat_sc0", sc0, 65535);
    check("cap_speed0", dut0.speed, 8);

    #2;
    clr = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    clr = 1'b1;
    step(0, 1, 1);
    step(1, 0, 1);
    check("post_reset_oh0", oh0, 638);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
